// File: rtl/phy_pkg.sv
// Shared PHY definitions: lane FSM state encoding and the comma symbol.
// Used by the receive synchronizer, the deserializer and the serializer.
package phy_pkg;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam logic [7:0] COMMA_K = 8'hBC;

  typedef enum logic [1:0] {
    S_HUNT   = ST_HUNT,
    S_VERIFY = ST_VERIFY,
    S_ACTIVE = ST_ACTIVE
  } phy_state_e;

endpackage

// File: rtl/phy_rx_shifter.sv
// Serial input history plus fill counter; presents the 8-bit window that
// includes the bit being sampled on the current edge.
module phy_rx_shifter (
  input  logic       not_clk_32f,
  input  logic       reset,
  input  logic       fill_clr,
  input  logic       data_in,
  output logic [7:0] sym_next,
  output logic       filled
);

  // Only 7 history bits are stored; the live input bit completes the window.
  logic [6:0] sreg;
  logic [3:0] fill_cnt;

  assign sym_next = {sreg, data_in};
  assign filled   = (fill_cnt >= 4'd7);

  always_ff @(posedge not_clk_32f) begin
    if (reset) begin
      sreg     <= '0;
      fill_cnt <= '0;
    end else begin
      sreg <= sym_next[6:0];
      if (fill_clr)
        fill_cnt <= '0;
      else if (fill_cnt != 4'd8)
        fill_cnt <= fill_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// Receive lane synchronizer: comma hunt at any bit offset, lock verification,
// and data byte delivery with idle-timeout loss-of-sync detection.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_HUNT   | searching every bit offset for the comma symbol
// S_VERIFY | aligned; counting consecutive commas towards LOCK_COUNT
// S_ACTIVE | locked; delivering non-comma bytes, watching idle timeout
module phy_rx_sync_ctrl
  import phy_pkg::*;
#(
  parameter logic [7:0] COMMA        = COMMA_K,
  parameter int         LOCK_COUNT   = 4,
  parameter int         IDLE_TIMEOUT = 64
) (
  input  logic       not_clk_32f,
  input  logic       reset,
  input  logic       enable,
  input  logic       data_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       sym_strobe,
  output logic       aligned,
  output logic       active,
  output logic       sync_lost,
  output logic [1:0] state
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [7:0] IDLE_N = 8'(IDLE_TIMEOUT);

  phy_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic [7:0] byte_out_d;
  logic       byte_valid_d, sym_strobe_d, sync_lost_d;
  logic       fill_clr;

  logic [7:0] sym_next;
  logic       filled;
  logic       is_comma, boundary;
  logic [3:0] comma_inc;
  logic [7:0] idle_inc;

  phy_rx_shifter u_shifter (
    .not_clk_32f (not_clk_32f),
    .reset       (reset),
    .fill_clr    (fill_clr),
    .data_in     (data_in),
    .sym_next    (sym_next),
    .filled      (filled)
  );

  assign is_comma  = (sym_next == COMMA);
  assign boundary  = (bit_cnt_q == 3'd7);
  assign comma_inc = comma_cnt_q + 4'd1;
  assign idle_inc  = idle_cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    comma_cnt_d  = comma_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    byte_out_d   = byte_out;
    byte_valid_d = 1'b0;
    sym_strobe_d = 1'b0;
    sync_lost_d  = 1'b0;
    fill_clr     = 1'b0;

    if (!enable) begin
      state_d     = S_HUNT;
      bit_cnt_d   = '0;
      comma_cnt_d = '0;
      idle_cnt_d  = '0;
      fill_clr    = 1'b1;
    end else begin
      case (state_q)
        S_HUNT: begin
          if (filled && is_comma) begin
            state_d     = S_VERIFY;
            bit_cnt_d   = '0;
            comma_cnt_d = 4'd1;
          end
        end
        S_VERIFY: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (boundary) begin
            sym_strobe_d = 1'b1;
            if (is_comma) begin
              comma_cnt_d = comma_inc;
              if (comma_inc == LOCK_N) begin
                state_d    = S_ACTIVE;
                idle_cnt_d = '0;
              end
            end else begin
              state_d     = S_HUNT;
              bit_cnt_d   = '0;
              comma_cnt_d = '0;
              fill_clr    = 1'b1;
            end
          end
        end
        S_ACTIVE: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (boundary) begin
            sym_strobe_d = 1'b1;
            if (is_comma) begin
              idle_cnt_d = '0;
            end else if (idle_inc < IDLE_N) begin
              byte_out_d   = sym_next;
              byte_valid_d = 1'b1;
              idle_cnt_d   = idle_inc;
            end else begin
              // Timed-out symbol is dropped, not delivered.
              sync_lost_d = 1'b1;
              state_d     = S_HUNT;
              bit_cnt_d   = '0;
              comma_cnt_d = '0;
              idle_cnt_d  = '0;
              fill_clr    = 1'b1;
            end
          end
        end
        default: begin
          state_d  = S_HUNT;
          fill_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge not_clk_32f) begin
    if (reset) begin
      state_q     <= S_HUNT;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      idle_cnt_q  <= '0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      sym_strobe  <= 1'b0;
      sync_lost   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      byte_out    <= byte_out_d;
      byte_valid  <= byte_valid_d;
      sym_strobe  <= sym_strobe_d;
      sync_lost   <= sync_lost_d;
    end
  end

  assign state   = state_q;
  assign aligned = (state_q != S_HUNT);
  assign active  = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Scoreboard bench for phy_rx_sync_ctrl: stimulus pushes expected byte and
// sync-loss events, a negedge monitor pops and compares them.
module tb_phy_rx_sync_ctrl;

  logic       not_clk_32f = 1'b0;
  logic       reset;
  logic       enable;
  logic       data_in;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       sym_strobe;
  logic       aligned;
  logic       active;
  logic       sync_lost;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Expected event: bit 8 set = sync_lost pulse, else byte pulse with value.
  logic [8:0] exp_q[$];
  localparam logic [8:0] EV_LOST = 9'h100;

  always #5 not_clk_32f = ~not_clk_32f;

  phy_rx_sync_ctrl #(
    .COMMA        (8'hBC),
    .LOCK_COUNT   (4),
    .IDLE_TIMEOUT (4)
  ) dut (
    .not_clk_32f (not_clk_32f),
    .reset       (reset),
    .enable      (enable),
    .data_in     (data_in),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .sym_strobe  (sym_strobe),
    .aligned     (aligned),
    .active      (active),
    .sync_lost   (sync_lost),
    .state       (state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge not_clk_32f) begin
    logic [8:0] e;
    if (byte_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_byte", {23'd0, 1'b0, byte_out}, 32'h1ff);
      else begin
        e = exp_q.pop_front();
        chk("byte_event", {23'd0, 1'b0, byte_out}, {23'd0, e});
      end
    end
    if (sync_lost === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_sync_lost", 32'h100, 32'h1ff);
      else begin
        e = exp_q.pop_front();
        chk("sync_lost_event", {23'd0, EV_LOST}, {23'd0, e});
      end
    end
  end

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge not_clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_head(input logic [7:0] v);
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
  endtask

  initial begin
    logic [7:0] v;
    reset   = 1'b1;
    enable  = 1'b1;
    data_in = 1'b0;
    repeat (3) @(posedge not_clk_32f);
    #1;
    reset = 1'b0;
    chk("rst_byte_out", {24'd0, byte_out}, 32'h00);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_flags", {27'd0, byte_valid, sym_strobe, aligned, active, sync_lost}, 32'd0);

    // Lock from a stream offset by three junk bits.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("hunt_state", {30'd0, state}, 32'd0);
    v = 8'hBC;
    send_head(v);
    chk("aligned_before_comma", {31'd0, aligned}, 32'd0);
    send_bit(v[0]);
    chk("aligned_on_detect", {31'd0, aligned}, 32'd1);
    chk("verify_state", {30'd0, state}, 32'd1);
    send_byte(8'hBC);
    chk("verify_2nd", {30'd0, state}, 32'd1);
    chk("strobe_boundary", {31'd0, sym_strobe}, 32'd1);
    send_byte(8'hBC);
    chk("verify_3rd_active", {31'd0, active}, 32'd0);
    send_byte(8'hBC);
    chk("lock_state", {30'd0, state}, 32'd2);
    chk("lock_active", {31'd0, active}, 32'd1);

    // Data delivery with interleaved comma.
    exp_q.push_back(9'h05A);
    exp_q.push_back(9'h0C3);
    send_byte(8'hBC);
    send_byte(8'h5A);
    chk("byte_5a", {24'd0, byte_out}, 32'h5A);
    send_byte(8'hBC);
    chk("byte_hold", {24'd0, byte_out}, 32'h5A);
    send_byte(8'hC3);
    chk("byte_c3", {24'd0, byte_out}, 32'hC3);
    chk("still_active", {30'd0, state}, 32'd2);

    // Force HUNT, then fail verification on a non-comma.
    enable = 1'b0;
    send_bit(1'b0);
    chk("enable_low_hunt", {30'd0, state}, 32'd0);
    enable = 1'b1;
    send_byte(8'hBC);
    chk("reverify_1", {30'd0, state}, 32'd1);
    send_byte(8'hBC);
    send_byte(8'h7E);
    chk("verify_fail_state", {30'd0, state}, 32'd0);
    chk("verify_fail_active", {31'd0, active}, 32'd0);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    chk("relock_3_commas", {30'd0, state}, 32'd1);
    send_byte(8'hBC);
    chk("relock_4_commas", {30'd0, state}, 32'd2);

    // Enable dropped on a boundary carrying a data byte.
    v = 8'h99;
    send_head(v);
    enable = 1'b0;
    send_bit(v[0]);
    chk("en_drop_state", {30'd0, state}, 32'd0);
    chk("en_drop_flags", {30'd0, byte_valid, sync_lost}, 32'd0);
    chk("en_drop_byte_hold", {24'd0, byte_out}, 32'hC3);
    enable = 1'b1;

    // Relock, deliver, then reset mid-symbol.
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    chk("lock_before_reset", {30'd0, state}, 32'd2);
    exp_q.push_back(9'h05A);
    send_byte(8'h5A);
    send_bit(1'b1); send_bit(1'b0);
    reset = 1'b1;
    send_bit(1'b1);
    reset = 1'b0;
    chk("mid_rst_byte_out", {24'd0, byte_out}, 32'h00);
    chk("mid_rst_state", {30'd0, state}, 32'd0);
    chk("mid_rst_flags", {27'd0, byte_valid, sym_strobe, aligned, active, sync_lost}, 32'd0);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    chk("post_rst_3_commas", {31'd0, active}, 32'd0);
    send_byte(8'hBC);
    chk("post_rst_4_commas", {31'd0, active}, 32'd1);

    // Idle timeout of 4 non-comma symbols.
    exp_q.push_back(9'h011);
    exp_q.push_back(9'h022);
    exp_q.push_back(9'h033);
    exp_q.push_back(EV_LOST);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    chk("timeout_state", {30'd0, state}, 32'd0);
    chk("timeout_active", {31'd0, active}, 32'd0);
    chk("timeout_sync_lost", {31'd0, sync_lost}, 32'd1);
    chk("timeout_byte_hold", {24'd0, byte_out}, 32'h33);
    send_bit(1'b0);
    chk("sync_lost_pulse_end", {31'd0, sync_lost}, 32'd0);

    repeat (16) send_bit(1'b0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
